gpio_responder: RTL and testbench

GPIO_RESPONDER -- requirements
Module: gpio_responder

---
 rtl/gpio_responder.sv | 169 ++++++++++++++++
 tb/tb_gpio_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_responder.sv
// Beat responder for a GPIO agent: paces beats with a ready handshake and raises
// an interrupt per completed burst, keeping per-address-space burst counters.
module gpio_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter bit          HOLD_ON_IRQ = 1'b1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               addr_space_1,
   input  logic               addr_space_0,
   input  logic               last,
   input  logic               irq_clr,
   output logic               ready,
   output logic               irq,
   output logic [1:0]         irq_space,
   output logic [CNT_W-1:0]   beat_cnt,
   output logic [4*CNT_W-1:0] burst_cnt,
   output logic               err
);

   // state  | meaning
   // ACCEPT | ready high, a beat is taken on every edge
   // WAIT   | ready low for WAIT_CYCLES cycles after a beat (or one cycle after reset)
   // HOLD   | ready low after a burst end until irq_clr
   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   localparam logic [3:0]       WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q;
   logic [3:0]       wait_q;
   logic             ready_q;

   logic             in_burst_q, in_burst_d;
   logic [1:0]       bspace_q, bspace_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic             irq_q, irq_d;
   logic             err_q, err_d;
   logic [1:0]       ispace_q, ispace_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] bc_q [4];
   logic [CNT_W-1:0] bc_d [4];

   logic [1:0]       space;
   logic [1:0]       cur_space;
   logic [CNT_W-1:0] run_inc;

   assign space = {addr_space_1, addr_space_0};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
         wait_q  <= 4'd0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (last && HOLD_ON_IRQ) begin
                  state_q <= ST_HOLD;
                  ready_q <= 1'b0;
               end else if (WAIT_CYCLES > 0) begin
                  state_q <= ST_WAIT;
                  wait_q  <= WAIT_LOAD;
                  ready_q <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (wait_q == 4'd0) begin
                  state_q <= ST_ACCEPT;
                  ready_q <= 1'b1;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            ST_HOLD: begin
               if (irq_clr) begin
                  if (WAIT_CYCLES > 0) begin
                     state_q <= ST_WAIT;
                     wait_q  <= WAIT_LOAD;
                  end else begin
                     state_q <= ST_ACCEPT;
                     ready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_WAIT;
               wait_q  <= 4'd0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      in_burst_d = in_burst_q;
      bspace_d   = bspace_q;
      run_d      = run_q;
      irq_d      = irq_q;
      err_d      = err_q;
      ispace_d   = ispace_q;
      beat_d     = beat_q;
      for (int s = 0; s < 4; s++) bc_d[s] = bc_q[s];

      cur_space = in_burst_q ? bspace_q : space;
      run_inc   = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);

      if (irq_clr && irq_q) begin
         irq_d = 1'b0;
         err_d = 1'b0;
      end

      // An irq_clr on the completing edge acknowledges the old interrupt, so no overrun.
      if (ready_q) begin
         if (in_burst_q && (space != bspace_q)) err_d = 1'b1;
         if (last) begin
            if (irq_q && !irq_clr) err_d = 1'b1;
            beat_d          = run_inc;
            ispace_d        = cur_space;
            bc_d[cur_space] = bc_q[cur_space] + CNT_W'(1);
            irq_d           = 1'b1;
            in_burst_d      = 1'b0;
            run_d           = '0;
         end else begin
            in_burst_d = 1'b1;
            bspace_d   = cur_space;
            run_d      = run_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_burst_q <= 1'b0;
         bspace_q   <= 2'd0;
         run_q      <= '0;
         irq_q      <= 1'b0;
         err_q      <= 1'b0;
         ispace_q   <= 2'd0;
         beat_q     <= '0;
         for (int s = 0; s < 4; s++) bc_q[s] <= '0;
      end else begin
         in_burst_q <= in_burst_d;
         bspace_q   <= bspace_d;
         run_q      <= run_d;
         irq_q      <= irq_d;
         err_q      <= err_d;
         ispace_q   <= ispace_d;
         beat_q     <= beat_d;
         for (int s = 0; s < 4; s++) bc_q[s] <= bc_d[s];
      end
   end

   assign ready     = ready_q;
   assign irq       = irq_q;
   assign err       = err_q;
   assign irq_space = ispace_q;
   assign beat_cnt  = beat_q;

   for (genvar g = 0; g < 4; g++) begin : g_bc
      assign burst_cnt[g*CNT_W +: CNT_W] = bc_q[g];
   end

endmodule

// File: tb/tb_gpio_responder.sv
// Bench for gpio_responder: three configurations driven side by side, directed
// scenarios with fixed expectations plus a randomized run against a burst-level model.
module tb_gpio_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] sp  [3];
   logic       lst [3];
   logic       clr [3];

   logic        rdy  [3];
   logic        irqo [3];
   logic        erro [3];
   logic [1:0]  isp  [3];
   logic [7:0]  bt   [3];
   logic [31:0] bcv  [3];

   logic        r0, r1, r2, q0, q1, q2, e0, e1, e2;
   logic [1:0]  s0, s1, s2, bt2;
   logic [7:0]  bt0, bt1, bc2;
   logic [31:0] bc0, bc1;

   gpio_responder u_def (
      .clk(clk), .rst_n(rst_n), .addr_space_1(sp[0][1]), .addr_space_0(sp[0][0]),
      .last(lst[0]), .irq_clr(clr[0]), .ready(r0), .irq(q0), .irq_space(s0),
      .beat_cnt(bt0), .burst_cnt(bc0), .err(e0));

   gpio_responder #(.WAIT_CYCLES(0), .HOLD_ON_IRQ(1'b0), .CNT_W(8)) u_fast (
      .clk(clk), .rst_n(rst_n), .addr_space_1(sp[1][1]), .addr_space_0(sp[1][0]),
      .last(lst[1]), .irq_clr(clr[1]), .ready(r1), .irq(q1), .irq_space(s1),
      .beat_cnt(bt1), .burst_cnt(bc1), .err(e1));

   gpio_responder #(.WAIT_CYCLES(0), .HOLD_ON_IRQ(1'b0), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .addr_space_1(sp[2][1]), .addr_space_0(sp[2][0]),
      .last(lst[2]), .irq_clr(clr[2]), .ready(r2), .irq(q2), .irq_space(s2),
      .beat_cnt(bt2), .burst_cnt(bc2), .err(e2));

   assign rdy[0] = r0;  assign rdy[1] = r1;  assign rdy[2] = r2;
   assign irqo[0] = q0; assign irqo[1] = q1; assign irqo[2] = q2;
   assign erro[0] = e0; assign erro[1] = e1; assign erro[2] = e2;
   assign isp[0] = s0;  assign isp[1] = s1;  assign isp[2] = s2;
   assign bt[0] = bt0;  assign bt[1] = bt1;  assign bt[2] = {6'd0, bt2};
   assign bcv[0] = bc0; assign bcv[1] = bc1; assign bcv[2] = {24'd0, bc2};

   int W_P  [3] = '{2, 0, 0};
   int H_P  [3] = '{1, 0, 0};
   int CW_P [3] = '{8, 8, 2};

   int checks = 0;
   int failures = 0;

   // Reference model: ready is low while stalls remain or while holding for an ack.
   int m_stall [3];
   bit m_hold  [3];
   bit m_inb   [3];
   int m_bsp   [3];
   int m_run   [3];
   bit m_irq   [3];
   bit m_err   [3];
   int m_isp   [3];
   int m_beat  [3];
   int m_bc    [3][4];

   function automatic void model_step();
      for (int k = 0; k < 3; k++) begin
         bit rdy_e, irq_n, err_n;
         int mx;
         if (!rst_n) begin
            m_stall[k] = 1; m_hold[k] = 0; m_inb[k] = 0; m_bsp[k] = 0; m_run[k] = 0;
            m_irq[k] = 0; m_err[k] = 0; m_isp[k] = 0; m_beat[k] = 0;
            for (int s = 0; s < 4; s++) m_bc[k][s] = 0;
            continue;
         end
         rdy_e = !m_hold[k] && (m_stall[k] == 0);
         mx    = (1 << CW_P[k]) - 1;
         irq_n = m_irq[k];
         err_n = m_err[k];
         if (clr[k] && m_irq[k]) begin
            irq_n = 0;
            err_n = 0;
         end
         if (rdy_e) begin
            if (m_inb[k] && int'(sp[k]) != m_bsp[k]) err_n = 1;
            if (!m_inb[k]) begin
               m_bsp[k] = int'(sp[k]);
               m_run[k] = 0;
            end
            m_run[k] = (m_run[k] < mx) ? m_run[k] + 1 : mx;
            if (lst[k]) begin
               if (m_irq[k] && !clr[k]) err_n = 1;
               m_beat[k] = m_run[k];
               m_isp[k]  = m_bsp[k];
               m_bc[k][m_bsp[k]] = (m_bc[k][m_bsp[k]] + 1) % (mx + 1);
               irq_n     = 1;
               m_inb[k]  = 0;
               m_run[k]  = 0;
               if (H_P[k] != 0) m_hold[k] = 1;
               else m_stall[k] = W_P[k];
            end else begin
               m_inb[k]   = 1;
               m_stall[k] = W_P[k];
            end
         end else if (m_hold[k]) begin
            if (clr[k]) begin
               m_hold[k]  = 0;
               m_stall[k] = W_P[k];
            end
         end else if (m_stall[k] > 0) begin
            m_stall[k]--;
         end
         m_irq[k] = irq_n;
         m_err[k] = err_n;
      end
   endfunction

   function automatic int bc_field(int k, int s);
      return int'((bcv[k] >> (s * CW_P[k])) & ((32'd1 << CW_P[k]) - 1));
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 3; k++) begin
         sp[k] = 2'd0; lst[k] = 1'b0; clr[k] = 1'b0;
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++; if (rdy[k] !== 1'b0) begin failures++; $display("FAIL reset_ready dut%0d got=%b exp=0", k, rdy[k]); end
         checks++; if (irqo[k] !== 1'b0) begin failures++; $display("FAIL reset_irq dut%0d got=%b exp=0", k, irqo[k]); end
         checks++; if (erro[k] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b exp=0", k, erro[k]); end
         checks++; if (isp[k] !== 2'd0) begin failures++; $display("FAIL reset_irq_space dut%0d got=%0d exp=0", k, isp[k]); end
         checks++; if (bt[k] !== 8'd0) begin failures++; $display("FAIL reset_beat_cnt dut%0d got=%0d exp=0", k, bt[k]); end
         checks++; if (bcv[k] !== 32'd0) begin failures++; $display("FAIL reset_burst_cnt dut%0d got=%h exp=0", k, bcv[k]); end
      end
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++; if (rdy[k] !== 1'b1) begin failures++; $display("FAIL release_ready dut%0d got=%b exp=1", k, rdy[k]); end
      end
   endtask

   task automatic test_basic_burst();
      do_reset();
      sp[0] = 2'd2; lst[0] = 1'b0;
      for (int b = 0; b < 2; b++) begin
         tick();
         checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL basic_wait1 beat%0d got=%b exp=0", b, rdy[0]); end
         tick();
         checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL basic_wait2 beat%0d got=%b exp=0", b, rdy[0]); end
         tick();
         checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL basic_ready_back beat%0d got=%b exp=1", b, rdy[0]); end
      end
      lst[0] = 1'b1;
      tick();
      lst[0] = 1'b0;
      checks++; if (irqo[0] !== 1'b1) begin failures++; $display("FAIL basic_irq got=%b exp=1", irqo[0]); end
      checks++; if (bt[0] !== 8'd3) begin failures++; $display("FAIL basic_beat_cnt got=%0d exp=3", bt[0]); end
      checks++; if (isp[0] !== 2'd2) begin failures++; $display("FAIL basic_irq_space got=%0d exp=2", isp[0]); end
      checks++; if (bc_field(0, 2) !== 1) begin failures++; $display("FAIL basic_burst_cnt2 got=%0d exp=1", bc_field(0, 2)); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL basic_hold cyc%0d got=%b exp=0", i, rdy[0]); end
         tick();
      end
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      checks++; if (irqo[0] !== 1'b0) begin failures++; $display("FAIL basic_irq_cleared got=%b exp=0", irqo[0]); end
      checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL basic_post_clr1 got=%b exp=0", rdy[0]); end
      tick();
      checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL basic_post_clr2 got=%b exp=0", rdy[0]); end
      tick();
      checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL basic_post_clr_ready got=%b exp=1", rdy[0]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      sp[1] = 2'd1; lst[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (rdy[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready i%0d got=%b exp=1", i, rdy[1]); end
         checks++; if (bc_field(1, 1) !== i + 1) begin failures++; $display("FAIL b2b_burst_cnt1 i%0d got=%0d exp=%0d", i, bc_field(1, 1), i + 1); end
         checks++; if (erro[1] !== (i >= 1)) begin failures++; $display("FAIL b2b_err i%0d got=%b exp=%b", i, erro[1], (i >= 1)); end
         checks++; if (bt[1] !== 8'd1) begin failures++; $display("FAIL b2b_beat_cnt i%0d got=%0d exp=1", i, bt[1]); end
      end
   endtask

   task automatic test_space_change();
      do_reset();
      sp[1] = 2'd0; lst[1] = 1'b0;
      tick();
      tick();
      sp[1] = 2'd3; lst[1] = 1'b1;
      tick();
      checks++; if (erro[1] !== 1'b1) begin failures++; $display("FAIL space_err got=%b exp=1", erro[1]); end
      checks++; if (isp[1] !== 2'd0) begin failures++; $display("FAIL space_irq_space got=%0d exp=0", isp[1]); end
      checks++; if (bc_field(1, 0) !== 1) begin failures++; $display("FAIL space_burst_cnt0 got=%0d exp=1", bc_field(1, 0)); end
      checks++; if (bc_field(1, 3) !== 0) begin failures++; $display("FAIL space_burst_cnt3 got=%0d exp=0", bc_field(1, 3)); end
      checks++; if (bt[1] !== 8'd3) begin failures++; $display("FAIL space_beat_cnt got=%0d exp=3", bt[1]); end
   endtask

   task automatic test_saturate_wrap();
      do_reset();
      sp[2] = 2'd3; lst[2] = 1'b0;
      repeat (4) tick();
      lst[2] = 1'b1;
      tick();
      checks++; if (bt[2] !== 8'd3) begin failures++; $display("FAIL sat_beat_cnt got=%0d exp=3", bt[2]); end
      checks++; if (bc_field(2, 3) !== 1) begin failures++; $display("FAIL sat_burst_cnt3 got=%0d exp=1", bc_field(2, 3)); end
      repeat (3) tick();
      checks++; if (bc_field(2, 3) !== 0) begin failures++; $display("FAIL wrap_burst_cnt3_zero got=%0d exp=0", bc_field(2, 3)); end
      tick();
      lst[2] = 1'b0;
      checks++; if (bc_field(2, 3) !== 1) begin failures++; $display("FAIL wrap_burst_cnt3 got=%0d exp=1", bc_field(2, 3)); end
      checks++; if (bt[2] !== 8'd1) begin failures++; $display("FAIL wrap_beat_cnt got=%0d exp=1", bt[2]); end
   endtask

   task automatic test_clr_same_edge();
      do_reset();
      sp[1] = 2'd2; lst[1] = 1'b1;
      tick();
      checks++; if (irqo[1] !== 1'b1) begin failures++; $display("FAIL clr_edge_first_irq got=%b exp=1", irqo[1]); end
      clr[1] = 1'b1;
      tick();
      checks++; if (irqo[1] !== 1'b1) begin failures++; $display("FAIL clr_edge_irq got=%b exp=1", irqo[1]); end
      checks++; if (erro[1] !== 1'b0) begin failures++; $display("FAIL clr_edge_err got=%b exp=0", erro[1]); end
      lst[1] = 1'b0;
      tick();
      clr[1] = 1'b0;
      checks++; if (irqo[1] !== 1'b0) begin failures++; $display("FAIL clr_alone_irq got=%b exp=0", irqo[1]); end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      sp[0] = 2'd1; lst[0] = 1'b0;
      tick();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", rdy[0]); end
      checks++; if (irqo[0] !== 1'b0) begin failures++; $display("FAIL midrst_irq got=%b exp=0", irqo[0]); end
      checks++; if (bt[0] !== 8'd0) begin failures++; $display("FAIL midrst_beat_cnt got=%0d exp=0", bt[0]); end
      checks++; if (bcv[0] !== 32'd0) begin failures++; $display("FAIL midrst_burst_cnt got=%h exp=0", bcv[0]); end
      rst_n = 1'b1;
      tick();
      checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL midrst_release_ready got=%b exp=1", rdy[0]); end
      lst[0] = 1'b1;
      tick();
      lst[0] = 1'b0;
      checks++; if (bt[0] !== 8'd1) begin failures++; $display("FAIL midrst_new_beat_cnt got=%0d exp=1", bt[0]); end
      checks++; if (isp[0] !== 2'd1) begin failures++; $display("FAIL midrst_new_irq_space got=%0d exp=1", isp[0]); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 2500; c++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         for (int k = 0; k < 3; k++) begin
            sp[k]  = 2'($urandom_range(0, 3));
            lst[k] = ($urandom_range(0, 3) == 0);
            clr[k] = ($urandom_range(0, 7) == 0);
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            bit exp_rdy;
            exp_rdy = !m_hold[k] && (m_stall[k] == 0);
            checks++; if (rdy[k] !== exp_rdy) begin failures++; $display("FAIL rnd_ready dut%0d cyc%0d got=%b exp=%b", k, c, rdy[k], exp_rdy); end
            checks++; if (irqo[k] !== m_irq[k]) begin failures++; $display("FAIL rnd_irq dut%0d cyc%0d got=%b exp=%b", k, c, irqo[k], m_irq[k]); end
            checks++; if (erro[k] !== m_err[k]) begin failures++; $display("FAIL rnd_err dut%0d cyc%0d got=%b exp=%b", k, c, erro[k], m_err[k]); end
            checks++; if (int'(isp[k]) !== m_isp[k]) begin failures++; $display("FAIL rnd_irq_space dut%0d cyc%0d got=%0d exp=%0d", k, c, isp[k], m_isp[k]); end
            checks++; if (int'(bt[k]) !== m_beat[k]) begin failures++; $display("FAIL rnd_beat_cnt dut%0d cyc%0d got=%0d exp=%0d", k, c, bt[k], m_beat[k]); end
            for (int s = 0; s < 4; s++) begin
               checks++; if (bc_field(k, s) !== m_bc[k][s]) begin failures++; $display("FAIL rnd_burst_cnt dut%0d cyc%0d space%0d got=%0d exp=%0d", k, c, s, bc_field(k, s), m_bc[k][s]); end
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic_burst();
      test_back_to_back();
      test_space_change();
      test_saturate_wrap();
      test_clr_same_edge();
      test_reset_midburst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
